// File: rtl/fft4_stream.sv
// Streaming 4-point radix-2 FFT/IFFT: collect 4 samples, two butterfly stages, emit 4 bins.
// Define FFT4_STREAM_SCALE_EN to arithmetically scale each bin by 1/4 (floor).
module fft4_stream #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_re,
  input  logic [W-1:0] in_im,
  input  logic         inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W+1:0] out_re,
  output logic [W+1:0] out_im,
  output logic [1:0]   out_idx,
  output logic         out_last
);

  typedef enum logic [1:0] {
    COLLECT,
    BF1,
    BF2,
    EMIT
  } state_e;

  state_e state_q;

  logic [1:0]   cnt_q;
  logic [1:0]   oidx_q;
  logic [1:0]   nidx;
  logic         inv_q;
  logic         ov_q;
  logic         olast_q;
  logic [W+1:0] ore_q;
  logic [W+1:0] oim_q;
  logic         acc;

  logic [W-1:0] xr_q [4];
  logic [W-1:0] xi_q [4];

  logic [W:0] a0r_q, a0i_q, a1r_q, a1i_q;
  logic [W:0] b0r_q, b0i_q, b1r_q, b1i_q;
  logic [W:0] a0r_d, a0i_d, a1r_d, a1i_d;
  logic [W:0] b0r_d, b0i_d, b1r_d, b1i_d;

  logic [W+1:0] bin_re_q [4];
  logic [W+1:0] bin_im_q [4];
  logic [W+1:0] bin_re_d [4];
  logic [W+1:0] bin_im_d [4];

  logic [W+1:0] x1r_f, x1i_f, x3r_f, x3i_f;

  function automatic logic [W:0] sx1(logic [W-1:0] v);
    return {v[W-1], v};
  endfunction

  function automatic logic [W+1:0] sx2(logic [W:0] v);
    return {v[W], v};
  endfunction

  function automatic logic [W+1:0] scl(logic [W+1:0] v);
`ifdef FFT4_STREAM_SCALE_EN
    return $signed(v) >>> 2;
`else
    return v;
`endif
  endfunction

  // in_ready is gated by rst_n so it reads 0 throughout reset
  assign in_ready  = rst_n && (state_q == COLLECT);
  assign acc       = in_valid && in_ready;
  assign nidx      = oidx_q + 2'd1;

  assign out_valid = ov_q;
  assign out_re    = ore_q;
  assign out_im    = oim_q;
  assign out_idx   = oidx_q;
  assign out_last  = olast_q;

  assign a0r_d = sx1(xr_q[0]) + sx1(xr_q[2]);
  assign a0i_d = sx1(xi_q[0]) + sx1(xi_q[2]);
  assign a1r_d = sx1(xr_q[0]) - sx1(xr_q[2]);
  assign a1i_d = sx1(xi_q[0]) - sx1(xi_q[2]);
  assign b0r_d = sx1(xr_q[1]) + sx1(xr_q[3]);
  assign b0i_d = sx1(xi_q[1]) + sx1(xi_q[3]);
  assign b1r_d = sx1(xr_q[1]) - sx1(xr_q[3]);
  assign b1i_d = sx1(xi_q[1]) - sx1(xi_q[3]);

  // Multiplying b1 by -j (forward) or +j (inverse) is a re/im swap
  assign x1r_f = sx2(a1r_q) + sx2(b1i_q);
  assign x1i_f = sx2(a1i_q) - sx2(b1r_q);
  assign x3r_f = sx2(a1r_q) - sx2(b1i_q);
  assign x3i_f = sx2(a1i_q) + sx2(b1r_q);

  always_comb begin
    bin_re_d[0] = scl(sx2(a0r_q) + sx2(b0r_q));
    bin_im_d[0] = scl(sx2(a0i_q) + sx2(b0i_q));
    bin_re_d[2] = scl(sx2(a0r_q) - sx2(b0r_q));
    bin_im_d[2] = scl(sx2(a0i_q) - sx2(b0i_q));
    bin_re_d[1] = scl(x1r_f);
    bin_im_d[1] = scl(x1i_f);
    bin_re_d[3] = scl(x3r_f);
    bin_im_d[3] = scl(x3i_f);
    if (inv_q) begin
      bin_re_d[1] = scl(x3r_f);
      bin_im_d[1] = scl(x3i_f);
      bin_re_d[3] = scl(x1r_f);
      bin_im_d[3] = scl(x1i_f);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      oidx_q  <= '0;
      inv_q   <= 1'b0;
      ov_q    <= 1'b0;
      olast_q <= 1'b0;
      ore_q   <= '0;
      oim_q   <= '0;
      a0r_q   <= '0;
      a0i_q   <= '0;
      a1r_q   <= '0;
      a1i_q   <= '0;
      b0r_q   <= '0;
      b0i_q   <= '0;
      b1r_q   <= '0;
      b1i_q   <= '0;
      for (int k = 0; k < 4; k++) begin
        xr_q[k]     <= '0;
        xi_q[k]     <= '0;
        bin_re_q[k] <= '0;
        bin_im_q[k] <= '0;
      end
    end else begin
      unique case (state_q)
        COLLECT: begin
          if (acc) begin
            xr_q[cnt_q] <= in_re;
            xi_q[cnt_q] <= in_im;
            if (cnt_q == 2'd0) inv_q <= inv;
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) state_q <= BF1;
          end
        end
        BF1: begin
          a0r_q   <= a0r_d;
          a0i_q   <= a0i_d;
          a1r_q   <= a1r_d;
          a1i_q   <= a1i_d;
          b0r_q   <= b0r_d;
          b0i_q   <= b0i_d;
          b1r_q   <= b1r_d;
          b1i_q   <= b1i_d;
          state_q <= BF2;
        end
        BF2: begin
          for (int k = 0; k < 4; k++) begin
            bin_re_q[k] <= bin_re_d[k];
            bin_im_q[k] <= bin_im_d[k];
          end
          state_q <= EMIT;
        end
        EMIT: begin
          // First EMIT cycle loads the output register with bin 0
          if (!ov_q) begin
            ov_q    <= 1'b1;
            oidx_q  <= 2'd0;
            olast_q <= 1'b0;
            ore_q   <= bin_re_q[0];
            oim_q   <= bin_im_q[0];
          end else if (out_ready) begin
            if (oidx_q == 2'd3) begin
              ov_q    <= 1'b0;
              oidx_q  <= 2'd0;
              olast_q <= 1'b0;
              state_q <= COLLECT;
            end else begin
              oidx_q  <= nidx;
              olast_q <= (nidx == 2'd3);
              ore_q   <= bin_re_q[nidx];
              oim_q   <= bin_im_q[nidx];
            end
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

endmodule
